// File: rtl/gerenciador_pkg.sv
`default_nettype none
// ============================================================================
// gerenciador_pkg: shared FSM encoding, segment glyphs and BCD sizing helper.
// Revision: 1.0
// ============================================================================
package gerenciador_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_ENCODE = 2'd2
  } state_t;

  // Active-high glyphs, bit0 = a ... bit6 = g
  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_MINUS = 7'h40;
  localparam logic [6:0] SEG_DASH  = 7'h40;

  // Smallest n with 10^n >= 2^width, i.e. ceil(width*log10(2)).
  function automatic int calc_nb(input int width);
    longint unsigned lim;
    longint unsigned p;
    int n;
    lim = 64'd1 << width;
    p   = 64'd1;
    n   = 0;
    for (int i = 0; i < 20; i++) begin
      if (p < lim) begin
        p = p * 64'd10;
        n = n + 1;
      end
    end
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_encoder.sv
`default_nettype none
// ============================================================================
// seg7_encoder: BCD digit to active-high 7-segment pattern (bit0=a..bit6=g).
// Revision: 1.0
// ============================================================================
module seg7_encoder
  import gerenciador_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (digit)
      4'd0: seg = 7'h3F;
      4'd1: seg = 7'h06;
      4'd2: seg = 7'h5B;
      4'd3: seg = 7'h4F;
      4'd4: seg = 7'h66;
      4'd5: seg = 7'h6D;
      4'd6: seg = 7'h7D;
      4'd7: seg = 7'h07;
      4'd8: seg = 7'h7F;
      4'd9: seg = 7'h6F;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/gerenciador_display_7seg.sv
`default_nettype none
// ============================================================================
// gerenciador_display_7seg: periodic binary-to-7-segment display manager.
// Revision: 1.0
// ============================================================================
module gerenciador_display_7seg
  import gerenciador_pkg::*;
#(
  parameter int WIDTH         = 32,
  parameter int N_DIGITS      = 8,
  parameter int UPDATE_PERIOD = 50000,
  parameter int ACTIVE_LOW    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      entrada,
  input  logic                  signed_mode,
  input  logic                  blank_zeros,
  output logic [7*N_DIGITS-1:0] saida,
  output logic                  busy,
  output logic                  overflow
);

  localparam int NB   = calc_nb(WIDTH);
  localparam int BW   = 4 * NB;
  localparam int EXT  = (NB > N_DIGITS) ? NB : N_DIGITS;
  localparam int CW   = $clog2(UPDATE_PERIOD);
  localparam int SW   = $clog2(WIDTH);
  localparam logic [CW-1:0] TICK_LAST  = CW'(UPDATE_PERIOD - 1);
  localparam logic [SW-1:0] SHIFT_LAST = SW'(WIDTH - 1);
  localparam logic [7*N_DIGITS-1:0] SAIDA_RST = (ACTIVE_LOW != 0) ? '1 : '0;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [SW-1:0]         bitcnt_q, bitcnt_d;
  logic [WIDTH-1:0]      shift_q, shift_d;
  logic [BW-1:0]         bcd_q, bcd_d;
  logic                  neg_q, neg_d;
  logic                  blank_q, blank_d;
  logic                  busy_q, busy_d;
  logic                  ovf_q, ovf_d;
  logic [7*N_DIGITS-1:0] saida_q, saida_d;

  logic                  tick;
  logic                  in_neg;
  logic [WIDTH-1:0]      in_mag;
  logic [BW-1:0]         bcd_adj;
  logic [4*EXT-1:0]      bcd_ext;
  logic [6:0]            enc_seg [N_DIGITS];
  logic [7*N_DIGITS-1:0] segs_w;
  logic                  ovf_w;
  logic                  nz_above;
  logic                  hide;
  int                    lim;

  assign tick    = (cnt_q == TICK_LAST);
  assign in_neg  = signed_mode & entrada[WIDTH-1];
  // WIDTH-bit negation is exact for the most-negative value once read unsigned.
  assign in_mag  = in_neg ? (~entrada + 1'b1) : entrada;
  assign bcd_ext = (4*EXT)'(bcd_q);

  for (genvar k = 0; k < N_DIGITS; k++) begin : g_digit
    seg7_encoder u_enc (
      .digit (bcd_ext[4*k +: 4]),
      .seg   (enc_seg[k])
    );
  end

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < NB; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  // Digits above the display (or the minus slot) force overflow; blanking
  // scans from the top so inner zeros are never suppressed.
  always_comb begin
    lim      = neg_q ? (N_DIGITS - 1) : N_DIGITS;
    ovf_w    = 1'b0;
    nz_above = 1'b0;
    hide     = 1'b0;
    segs_w   = '0;
    for (int i = 0; i < NB; i++) begin
      if ((i >= lim) && (bcd_ext[4*i +: 4] != 4'd0)) ovf_w = 1'b1;
    end
    for (int i = N_DIGITS; i < EXT; i++) begin
      if (bcd_ext[4*i +: 4] != 4'd0) nz_above = 1'b1;
    end
    for (int k = N_DIGITS - 1; k >= 0; k--) begin
      if (bcd_ext[4*k +: 4] != 4'd0) nz_above = 1'b1;
      hide = blank_q && (k != 0) && !nz_above;
      if (ovf_w)                          segs_w[7*k +: 7] = SEG_DASH;
      else if (neg_q && k == N_DIGITS-1)  segs_w[7*k +: 7] = SEG_MINUS;
      else if (hide)                      segs_w[7*k +: 7] = SEG_BLANK;
      else                                segs_w[7*k +: 7] = enc_seg[k];
    end
  end

  always_comb begin
    cnt_d    = tick ? '0 : cnt_q + 1'b1;
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    shift_d  = shift_q;
    bcd_d    = bcd_q;
    neg_d    = neg_q;
    blank_d  = blank_q;
    busy_d   = busy_q;
    ovf_d    = ovf_q;
    saida_d  = saida_q;
    case (state_q)
      ST_IDLE: begin
        if (tick) begin
          neg_d    = in_neg;
          blank_d  = blank_zeros;
          shift_d  = in_mag;
          bcd_d    = '0;
          bitcnt_d = '0;
          busy_d   = 1'b1;
          state_d  = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        bcd_d    = {bcd_adj[BW-2:0], shift_q[WIDTH-1]};
        shift_d  = {shift_q[WIDTH-2:0], 1'b0};
        bitcnt_d = bitcnt_q + 1'b1;
        if (bitcnt_q == SHIFT_LAST) state_d = ST_ENCODE;
      end
      ST_ENCODE: begin
        saida_d = (ACTIVE_LOW != 0) ? ~segs_w : segs_w;
        ovf_d   = ovf_w;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      bitcnt_q <= '0;
      shift_q  <= '0;
      bcd_q    <= '0;
      neg_q    <= 1'b0;
      blank_q  <= 1'b0;
      busy_q   <= 1'b0;
      ovf_q    <= 1'b0;
      saida_q  <= SAIDA_RST;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bitcnt_q <= bitcnt_d;
      shift_q  <= shift_d;
      bcd_q    <= bcd_d;
      neg_q    <= neg_d;
      blank_q  <= blank_d;
      busy_q   <= busy_d;
      ovf_q    <= ovf_d;
      saida_q  <= saida_d;
    end
  end

  assign saida    = saida_q;
  assign busy     = busy_q;
  assign overflow = ovf_q;

endmodule
`default_nettype wire

// File: doc/gerenciador_display_7seg.md
GERENCIADOR_DISPLAY_7SEG -- requirements
Module: gerenciador_display_7seg

Interface
REQ-001 Parameter WIDTH, default 32: binary input width, 4..32.
REQ-002 Parameter N_DIGITS, default 8: number of 7-segment digits driven, 1..10.
REQ-003 Parameter UPDATE_PERIOD, default 50000: clk cycles between display refresh ticks, >= WIDTH+4.
REQ-004 Parameter ACTIVE_LOW, default 1: 1 means a lit segment is driven 0.
REQ-005 One clock; reset is asynchronous and active-high.
REQ-006 clk  input  1  system clock, all state on rising edge.
REQ-007 rst  input  1  asynchronous active-high reset.
REQ-008 entrada  input  WIDTH  value to display, sampled only at conversion start.
REQ-009 signed_mode  input  1  1 means entrada is two's complement; sampled with entrada.
REQ-010 blank_zeros  input  1  1 means leading-zero suppression; sampled with entrada.
REQ-011 saida  output  7*N_DIGITS  segments, digit k at [7k+6:7k], k=0 is units; bit 7k+0=a ... 7k+6=g.
REQ-012 busy  output  1  high while a conversion is in progress.
REQ-013 overflow  output  1  high while the displayed value does not fit N_DIGITS.

Function
REQ-014 Tick counter SHALL count 0..UPDATE_PERIOD-1 and wrap, asserting a one-cycle tick on the wrap cycle.
REQ-015 FSM states SHALL be IDLE, SHIFT and ENCODE; reset state IDLE.
REQ-016 IDLE: on tick, latch entrada, signed_mode and blank_zeros, load magnitude, clear the BCD register, set busy, go to SHIFT.
REQ-017 Magnitude = entrada if signed_mode=0 or MSB=0, else two's-complement negation in WIDTH+1 bits (most-negative value handled exactly).
REQ-018 SHIFT: iterative double-dabble, one bit per cycle, MSB first, add-3 to every BCD nibble >=5 before each shift; exactly WIDTH cycles, then go to ENCODE.
REQ-019 BCD register SHALL hold NB = ceil(WIDTH*log10(2)) digits (10 for WIDTH=32), independent of N_DIGITS.
REQ-020 ENCODE (one cycle): build all digits, register saida and overflow, clear busy, return to IDLE.
REQ-021 Latency: saida/overflow update exactly WIDTH+2 cycles after the tick cycle.
REQ-022 Unsigned overflow: any BCD digit at index >= N_DIGITS nonzero.
REQ-023 Signed negative: digit N_DIGITS-1 reserved for minus (segment g only); overflow if any digit at index >= N_DIGITS-1 nonzero.
REQ-024 On overflow every digit SHALL show a dash (segment g only).
REQ-025 blank_zeros=1: zero digits above the most significant nonzero digit are blank; digit 0 is never blanked (value 0 shows "0").
REQ-026 blank_zeros=0: all N_DIGITS digits show numerals (minus still replaces the top digit when negative).
REQ-027 Ticks arriving while busy SHALL be ignored; the counter keeps running.
REQ-028 entrada changes during SHIFT/ENCODE SHALL not affect the conversion in progress.
REQ-029 ACTIVE_LOW=1 SHALL invert every segment bit at the register input, including blanks.

Reset
REQ-030 rst SHALL force tick counter 0, FSM IDLE, busy 0, overflow 0, saida all segments unlit (all 1s if ACTIVE_LOW), BCD and shift registers 0.
REQ-031 rst asserted mid-conversion SHALL abort it with no partial update of saida; the first conversion after release starts on the next tick.

Structure
REQ-032 Package gerenciador_pkg SHALL hold the FSM state enum, segment constants SEG_BLANK, SEG_MINUS, SEG_DASH, and the NB digit-count function.
REQ-033 One sub-module, seg7_encoder (combinational 4-bit digit -> 7 segments, active-high), instantiated N_DIGITS times.
REQ-034 Target size 120-400 lines RTL; no division or modulo operators.

Verification (WIDTH=32, N_DIGITS=8, UPDATE_PERIOD=64, ACTIVE_LOW=1 unless noted)
REQ-035 Assert rst -> saida=all 1s, busy=0, overflow=0; release, no tick yet -> saida unchanged.
REQ-036 entrada=12345678, unsigned, blank_zeros=0 -> 34 cycles after tick, digits 7..0 show 1,2,3,4,5,6,7,8; overflow=0.
REQ-037 entrada=42, blank_zeros=1 -> digits 7..2 blank, digit1 "4", digit0 "2"; entrada=0 -> only digit0 "0".
REQ-038 entrada=-5 (32'hFFFFFFFB), signed_mode=1, blank_zeros=1 -> digit7 minus, digits 6..1 blank, digit0 "5"; entrada=-10000000 -> all dashes, overflow=1.
REQ-039 entrada=100000000 unsigned -> all dashes, overflow=1; then 99999999 -> all "9", overflow=0.
REQ-040 Change entrada and fire a tick mid-SHIFT -> result reflects the latched value, extra tick ignored; rst mid-SHIFT -> busy=0, saida all 1s.
